// File: rtl/fetch_queue_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit_if
// Bundles every non-clock/reset signal of the fetch queue unit.
//   master : the fetch queue unit itself
//            (drives I$ request, predictor hooks, decode-side bundle and count)
//   slave  : the surroundings (I$, branch predictor, decode, flush/redirect source)
// Port summary (direction seen from master):
//   in  flush, redirect_valid, redirect_pc     pipeline control
//   out ic_req, ic_paddr                       I$ line request
//   in  ic_valid, ic_rdata_line, ic_stall      I$ line response / busy
//   out bp_fetch_valid, bp_fetch_pc            predictor lookup / history update
//   in  bp_pred_taken/slot/target/hist         combinational prediction
//   out out_valid, out_pc, out_inst, out_mask  decode bundle (FIFO head)
//   out out_pred_taken/slot/target/hist        prediction carried with bundle
//   in  out_ready                              decode accepts head
//   out q_count                                FIFO occupancy
// -----------------------------------------------------------------------------
interface fetch_queue_unit_if #(
  parameter int ADDR_W      = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int LINE_WORDS  = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int HIST_W      = 8
);
  localparam int SLOT_W = $clog2(FETCH_WIDTH) + 1;
  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;

  logic                       flush;
  logic                       redirect_valid;
  logic [ADDR_W-1:0]          redirect_pc;
  logic                       ic_req;
  logic [ADDR_W-1:0]          ic_paddr;
  logic                       ic_valid;
  logic [32*LINE_WORDS-1:0]   ic_rdata_line;
  logic                       ic_stall;
  logic                       bp_fetch_valid;
  logic [ADDR_W-1:0]          bp_fetch_pc;
  logic                       bp_pred_taken;
  logic [SLOT_W-1:0]          bp_pred_slot;
  logic [ADDR_W-1:0]          bp_pred_target;
  logic [HIST_W-1:0]          bp_pred_hist;
  logic                       out_valid;
  logic                       out_ready;
  logic [ADDR_W-1:0]          out_pc;
  logic [32*FETCH_WIDTH-1:0]  out_inst;
  logic [FETCH_WIDTH-1:0]     out_mask;
  logic                       out_pred_taken;
  logic [SLOT_W-1:0]          out_pred_slot;
  logic [ADDR_W-1:0]          out_pred_target;
  logic [HIST_W-1:0]          out_pred_hist;
  logic [CNT_W-1:0]           q_count;

  modport master (
    input  flush, redirect_valid, redirect_pc,
    input  ic_valid, ic_rdata_line, ic_stall,
    input  bp_pred_taken, bp_pred_slot, bp_pred_target, bp_pred_hist,
    input  out_ready,
    output ic_req, ic_paddr,
    output bp_fetch_valid, bp_fetch_pc,
    output out_valid, out_pc, out_inst, out_mask,
    output out_pred_taken, out_pred_slot, out_pred_target, out_pred_hist,
    output q_count
  );

  modport slave (
    output flush, redirect_valid, redirect_pc,
    output ic_valid, ic_rdata_line, ic_stall,
    output bp_pred_taken, bp_pred_slot, bp_pred_target, bp_pred_hist,
    output out_ready,
    input  ic_req, ic_paddr,
    input  bp_fetch_valid, bp_fetch_pc,
    input  out_valid, out_pc, out_inst, out_mask,
    input  out_pred_taken, out_pred_slot, out_pred_target, out_pred_hist,
    input  q_count
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
// Front-end fetch stage. Holds the fetch PC and a one-line buffer of the I$.
// Each cycle the line containing the PC is either already buffered (hit) or
// arriving from the I$ (bypass); a bundle of up to FETCH_WIDTH instructions is
// cut from it, trimmed by the external branch prediction, and pushed into a
// QUEUE_DEPTH-entry FIFO that feeds decode through a valid/ready handshake.
// Ports:
//   clk    clock
//   rst_n  asynchronous reset, active-low
//   bus    fetch_queue_unit_if.master (I$, predictor, decode, flush/redirect)
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int                ADDR_W      = 32,
  parameter int                FETCH_WIDTH = 2,
  parameter int                LINE_WORDS  = 4,
  parameter int                QUEUE_DEPTH = 4,
  parameter int                HIST_W      = 8,
  parameter int                EPOCH_W     = 3,
  parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_queue_unit_if.master  bus
);

  localparam int SLOT_W = $clog2(FETCH_WIDTH) + 1;
  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int WIDX_W = $clog2(LINE_WORDS) + 1;
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int INST_W = 32 * FETCH_WIDTH;
  localparam logic [ADDR_W-1:0] LINE_OFF = ADDR_W'(LINE_WORDS * 4 - 1);

  // Line-aligned base address of a PC (used as the line-buffer tag).
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return a & ~LINE_OFF;
  endfunction

  // ---------------------------------------------------------------- state
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               started_q;
  logic               lb_valid_q, lb_valid_d;
  logic [ADDR_W-1:0]  lb_tag_q, lb_tag_d;
  logic [LINE_W-1:0]  lb_data_q, lb_data_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  pend_tag_q, pend_tag_d;
  logic [EPOCH_W-1:0] pend_epoch_q, pend_epoch_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [ADDR_W-1:0]  f_pc_q     [QUEUE_DEPTH];
  logic [INST_W-1:0]  f_inst_q   [QUEUE_DEPTH];
  logic [FETCH_WIDTH-1:0] f_mask_q [QUEUE_DEPTH];
  logic               f_taken_q  [QUEUE_DEPTH];
  logic [SLOT_W-1:0]  f_slot_q   [QUEUE_DEPTH];
  logic [ADDR_W-1:0]  f_tgt_q    [QUEUE_DEPTH];
  logic [HIST_W-1:0]  f_hist_q   [QUEUE_DEPTH];

  // ---------------------------------------------------------------- control
  logic               kill_s;
  logic [ADDR_W-1:0]  cur_line_s;
  logic               hit_s;
  logic               resp_ok_s;
  logic               bypass_s;
  logic               line_rdy_s;
  logic [LINE_W-1:0]  line_data_s;
  logic               ic_req_s;
  logic               full_s;
  logic               deq_s;
  logic               fire_s;
  logic [WIDX_W-1:0]  w_s;

  assign kill_s     = bus.flush || bus.redirect_valid;
  assign cur_line_s = line_addr(pc_q);
  assign hit_s      = lb_valid_q && (lb_tag_q == cur_line_s);
  // A response counts only if it answers a request issued in the current epoch;
  // a flush/redirect in the same cycle discards it.
  assign resp_ok_s  = bus.ic_valid && pend_q && (pend_epoch_q == epoch_q) && !kill_s;
  assign bypass_s   = resp_ok_s && (pend_tag_q == cur_line_s);
  assign line_rdy_s = hit_s || bypass_s;
  assign line_data_s = hit_s ? lb_data_q : bus.ic_rdata_line;
  // started_q keeps ic_req low until the first cycle after reset release.
  assign ic_req_s   = started_q && !line_rdy_s && !kill_s;
  assign full_s     = (count_q == CNT_W'(QUEUE_DEPTH));
  assign deq_s      = (count_q != {CNT_W{1'b0}}) && bus.out_ready && !kill_s;
  assign fire_s     = line_rdy_s && !bus.ic_stall && !kill_s && (!full_s || deq_s);
  assign w_s        = WIDX_W'((pc_q >> 2'd2) & ADDR_W'(LINE_WORDS - 1));

  // ---------------------------------------------------------------- bundle
  logic [INST_W-1:0]      inst_s;
  logic [FETCH_WIDTH-1:0] mask_s;
  logic                   taken_s;
  logic [SLOT_W-1:0]      slot_s;
  logic [ADDR_W-1:0]      tgt_s;
  logic [ADDR_W-1:0]      next_pc_s;

  // Cut the bundle out of the line and apply the prediction.
  always_comb begin
    int nv_v;
    int rem_v;
    inst_s  = {INST_W{1'b0}};
    mask_s  = {FETCH_WIDTH{1'b0}};
    rem_v   = LINE_WORDS - int'(w_s);
    // Bundles stop at the end of the line.
    nv_v    = (rem_v < FETCH_WIDTH) ? rem_v : FETCH_WIDTH;
    // A taken slot beyond the valid slots is not believable: treat as not taken.
    taken_s = bus.bp_pred_taken && (int'(bus.bp_pred_slot) < nv_v);
    slot_s  = taken_s ? bus.bp_pred_slot : {SLOT_W{1'b0}};
    tgt_s   = taken_s ? bus.bp_pred_target : {ADDR_W{1'b0}};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if ((i < nv_v) && (!taken_s || (i <= int'(bus.bp_pred_slot)))) begin
        mask_s[i]          = 1'b1;
        inst_s[i*32 +: 32] = line_data_s[((int'(w_s) + i) % LINE_WORDS) * 32 +: 32];
      end else begin
        mask_s[i]          = 1'b0;
        inst_s[i*32 +: 32] = 32'h0000_0000;
      end
    end
    if (taken_s) begin
      next_pc_s = bus.bp_pred_target;
    end else begin
      next_pc_s = pc_q + (ADDR_W'(nv_v) << 2'd2);
    end
  end

  // Next-state for PC, line buffer, pending request, epoch and FIFO pointers.
  always_comb begin
    pc_d         = pc_q;
    lb_valid_d   = lb_valid_q;
    lb_tag_d     = lb_tag_q;
    lb_data_d    = lb_data_q;
    pend_d       = pend_q;
    pend_tag_d   = pend_tag_q;
    pend_epoch_d = pend_epoch_q;
    epoch_d      = epoch_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    if (kill_s) begin
      pc_d       = bus.redirect_valid ? bus.redirect_pc : RESET_PC;
      lb_valid_d = 1'b0;
      pend_d     = 1'b0;
      epoch_d    = epoch_q + EPOCH_W'(1'b1);
      wptr_d     = {PTR_W{1'b0}};
      rptr_d     = {PTR_W{1'b0}};
      count_d    = {CNT_W{1'b0}};
    end else begin
      if (fire_s) begin
        pc_d   = next_pc_s;
        wptr_d = wptr_q + PTR_W'(1'b1);
      end else begin
        pc_d   = pc_q;
      end
      if (deq_s) begin
        rptr_d = rptr_q + PTR_W'(1'b1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({fire_s, deq_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
      if (resp_ok_s) begin
        lb_valid_d = 1'b1;
        lb_tag_d   = pend_tag_q;
        lb_data_d  = bus.ic_rdata_line;
        pend_d     = 1'b0;
      end else if (ic_req_s && !pend_q) begin
        pend_d       = 1'b1;
        pend_tag_d   = cur_line_s;
        pend_epoch_d = epoch_q;
      end else begin
        pend_d = pend_q;
      end
    end
  end

  // Control-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      started_q    <= 1'b0;
      lb_valid_q   <= 1'b0;
      lb_tag_q     <= {ADDR_W{1'b0}};
      lb_data_q    <= {LINE_W{1'b0}};
      pend_q       <= 1'b0;
      pend_tag_q   <= {ADDR_W{1'b0}};
      pend_epoch_q <= {EPOCH_W{1'b0}};
      epoch_q      <= {EPOCH_W{1'b0}};
      wptr_q       <= {PTR_W{1'b0}};
      rptr_q       <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
    end else begin
      pc_q         <= pc_d;
      started_q    <= 1'b1;
      lb_valid_q   <= lb_valid_d;
      lb_tag_q     <= lb_tag_d;
      lb_data_q    <= lb_data_d;
      pend_q       <= pend_d;
      pend_tag_q   <= pend_tag_d;
      pend_epoch_q <= pend_epoch_d;
      epoch_q      <= epoch_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
    end
  end

  // Bundle FIFO storage; written at the write pointer on every fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
        f_pc_q[k]    <= {ADDR_W{1'b0}};
        f_inst_q[k]  <= {INST_W{1'b0}};
        f_mask_q[k]  <= {FETCH_WIDTH{1'b0}};
        f_taken_q[k] <= 1'b0;
        f_slot_q[k]  <= {SLOT_W{1'b0}};
        f_tgt_q[k]   <= {ADDR_W{1'b0}};
        f_hist_q[k]  <= {HIST_W{1'b0}};
      end
    end else if (fire_s) begin
      f_pc_q[wptr_q]    <= pc_q;
      f_inst_q[wptr_q]  <= inst_s;
      f_mask_q[wptr_q]  <= mask_s;
      f_taken_q[wptr_q] <= taken_s;
      f_slot_q[wptr_q]  <= slot_s;
      f_tgt_q[wptr_q]   <= tgt_s;
      f_hist_q[wptr_q]  <= bus.bp_pred_hist;
    end else begin
      f_pc_q[wptr_q]    <= f_pc_q[wptr_q];
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.ic_req          = ic_req_s;
  assign bus.ic_paddr        = pc_q;
  assign bus.bp_fetch_valid  = fire_s;
  assign bus.bp_fetch_pc     = pc_q;
  assign bus.out_valid       = (count_q != {CNT_W{1'b0}});
  assign bus.out_pc          = f_pc_q[rptr_q];
  assign bus.out_inst        = f_inst_q[rptr_q];
  assign bus.out_mask        = f_mask_q[rptr_q];
  assign bus.out_pred_taken  = f_taken_q[rptr_q];
  assign bus.out_pred_slot   = f_slot_q[rptr_q];
  assign bus.out_pred_target = f_tgt_q[rptr_q];
  assign bus.out_pred_hist   = f_hist_q[rptr_q];
  assign bus.q_count         = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_unit
// Directed bench for fetch_queue_unit (default parameters). The stimulus block
// pushes the bundle it expects whenever it drives a cycle in which a bundle is
// enqueued; a monitor pops and compares at every dequeue.
// -----------------------------------------------------------------------------
module tb_fetch_queue_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  fetch_queue_unit_if bus ();

  fetch_queue_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] inst;
    logic [1:0]  mask;
    logic        taken;
    logic [1:0]  slot;
    logic [31:0] tgt;
    logic [7:0]  hist;
  } exp_t;

  exp_t sb[$];

  // Instruction word stored at address a in the modelled memory.
  function automatic logic [31:0] iw(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] base);
    return {iw(base + 32'd12), iw(base + 32'd8), iw(base + 32'd4), iw(base)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [63:0] inst, input logic [1:0] mask,
                      input logic taken, input logic [1:0] slot, input logic [31:0] tgt,
                      input logic [7:0] hist);
    exp_t e;
    e.pc = pc; e.inst = inst; e.mask = mask; e.taken = taken;
    e.slot = slot; e.tgt = tgt; e.hist = hist;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare the FIFO head at every accepted dequeue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !bus.flush && !bus.redirect_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 128'd1, 128'd0);
      end else begin
        exp_t e;
        logic [63:0] m;
        e = sb.pop_front();
        m = {{32{e.mask[1]}}, {32{e.mask[0]}}};
        check("out_pc", bus.out_pc, e.pc);
        check("out_mask", bus.out_mask, e.mask);
        check("out_inst", bus.out_inst & m, e.inst & m);
        check("out_pred_taken", bus.out_pred_taken, e.taken);
        check("out_pred_hist", bus.out_pred_hist, e.hist);
        if (e.taken) begin
          check("out_pred_slot", bus.out_pred_slot, e.slot);
          check("out_pred_target", bus.out_pred_target, e.tgt);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    bus.ic_valid = 1'b0; bus.ic_rdata_line = 128'h0; bus.ic_stall = 1'b0;
    bus.bp_pred_taken = 1'b0; bus.bp_pred_slot = 2'd0; bus.bp_pred_target = 32'h0;
    bus.bp_pred_hist = 8'h00; bus.out_ready = 1'b0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_q_count", bus.q_count, 3'd0);
    check("rst_ic_req", bus.ic_req, 1'b0);
    check("rst_bp_fetch_valid", bus.bp_fetch_valid, 1'b0);
    check("rst_ic_paddr", bus.ic_paddr, 32'h0);
    check("rst_out_pc", bus.out_pc, 32'h0);
    check("rst_out_mask", bus.out_mask, 2'b00);
    check("rst_out_inst", bus.out_inst, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Miss on line 0x0
    @(negedge clk);
    check("miss0_ic_req", bus.ic_req, 1'b1);
    check("miss0_ic_paddr", bus.ic_paddr, 32'h0);
    check("miss0_no_fire", bus.bp_fetch_valid, 1'b0);
    tick();

    // Response bypassed: bundle 0x0 enqueued the same cycle
    bus.ic_valid = 1'b1; bus.ic_rdata_line = line_of(32'h0); bus.bp_pred_hist = 8'h01;
    push(32'h0, {iw(32'h4), iw(32'h0)}, 2'b11, 1'b0, 2'd0, 32'h0, 8'h01);
    @(negedge clk);
    check("byp_fire", bus.bp_fetch_valid, 1'b1);
    check("byp_bp_pc", bus.bp_fetch_pc, 32'h0);
    tick();

    // Hit at 0x8
    bus.ic_valid = 1'b0; bus.bp_pred_hist = 8'h02;
    push(32'h8, {iw(32'hC), iw(32'h8)}, 2'b11, 1'b0, 2'd0, 32'h0, 8'h02);
    @(negedge clk);
    check("lat_out_valid", bus.out_valid, 1'b1);
    check("lat_q_count", bus.q_count, 3'd1);
    check("hit8_fire", bus.bp_fetch_valid, 1'b1);
    check("hit8_bp_pc", bus.bp_fetch_pc, 32'h8);
    tick();

    // Next line 0x10 misses; start draining
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("q2_count", bus.q_count, 3'd2);
    check("miss10_ic_req", bus.ic_req, 1'b1);
    check("miss10_paddr", bus.ic_paddr, 32'h10);
    tick();
    tick();

    // Drained; redirect to 0x100 while the 0x10 miss is pending
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    @(negedge clk);
    check("drain_out_valid", bus.out_valid, 1'b0);
    check("drain_q_count", bus.q_count, 3'd0);
    check("redir_ic_req", bus.ic_req, 1'b0);
    tick();

    // Old 0x10 response arrives: must be dropped
    bus.redirect_valid = 1'b0;
    bus.ic_valid = 1'b1; bus.ic_rdata_line = line_of(32'h10);
    @(negedge clk);
    check("stale_no_fire", bus.bp_fetch_valid, 1'b0);
    check("redir_ic_req2", bus.ic_req, 1'b1);
    check("redir_paddr", bus.ic_paddr, 32'h100);
    tick();

    // Line 0x100 arrives; predict taken at slot 0 to 0x40
    bus.ic_rdata_line = line_of(32'h100);
    bus.bp_pred_taken = 1'b1; bus.bp_pred_slot = 2'd0; bus.bp_pred_target = 32'h40;
    bus.bp_pred_hist = 8'h03;
    push(32'h100, {32'h0, iw(32'h100)}, 2'b01, 1'b1, 2'd0, 32'h40, 8'h03);
    @(negedge clk);
    check("stale_q_count", bus.q_count, 3'd0);
    check("pred_fire", bus.bp_fetch_valid, 1'b1);
    tick();

    bus.ic_valid = 1'b0; bus.bp_pred_taken = 1'b0;
    @(negedge clk);
    check("pred_paddr", bus.ic_paddr, 32'h40);
    check("pred_ic_req", bus.ic_req, 1'b1);
    tick();

    // Redirect to 0xC (last word of a line)
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hC;
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("c_paddr", bus.ic_paddr, 32'hC);
    check("c_ic_req", bus.ic_req, 1'b1);
    tick();

    // Line 0x0 arrives; slot-1 prediction is out of range and ignored
    bus.ic_valid = 1'b1; bus.ic_rdata_line = line_of(32'h0);
    bus.bp_pred_taken = 1'b1; bus.bp_pred_slot = 2'd1; bus.bp_pred_target = 32'h200;
    bus.bp_pred_hist = 8'h04;
    push(32'hC, {32'h0, iw(32'hC)}, 2'b01, 1'b0, 2'd0, 32'h0, 8'h04);
    @(negedge clk);
    check("c_fire", bus.bp_fetch_valid, 1'b1);
    tick();

    bus.ic_valid = 1'b0; bus.bp_pred_taken = 1'b0;
    @(negedge clk);
    check("c_next_paddr", bus.ic_paddr, 32'h10);
    check("c_next_ic_req", bus.ic_req, 1'b1);
    tick();

    // Fill the FIFO: line 0x10 with a loop prediction back to 0x10
    bus.out_ready = 1'b0;
    bus.ic_valid = 1'b1; bus.ic_rdata_line = line_of(32'h10);
    bus.bp_pred_taken = 1'b1; bus.bp_pred_slot = 2'd1; bus.bp_pred_target = 32'h10;
    for (int k = 0; k < 4; k++) begin
      bus.bp_pred_hist = 8'h05 + 8'(k);
      push(32'h10, {iw(32'h14), iw(32'h10)}, 2'b11, 1'b1, 2'd1, 32'h10, 8'h05 + 8'(k));
      tick();
      bus.ic_valid = 1'b0;
    end

    // Full and blocked
    bus.bp_pred_hist = 8'h09;
    @(negedge clk);
    check("full_q_count", bus.q_count, 3'd4);
    check("full_no_fire", bus.bp_fetch_valid, 1'b0);
    check("full_pc_frozen", bus.ic_paddr, 32'h10);
    check("full_out_valid", bus.out_valid, 1'b1);
    tick();

    // Enqueue and dequeue together while full
    bus.out_ready = 1'b1; bus.bp_pred_hist = 8'h0A;
    push(32'h10, {iw(32'h14), iw(32'h10)}, 2'b11, 1'b1, 2'd1, 32'h10, 8'h0A);
    @(negedge clk);
    check("full_enq_deq_fire", bus.bp_fetch_valid, 1'b1);
    tick();

    // Flush without redirect on a full FIFO
    bus.flush = 1'b1;
    @(negedge clk);
    check("enqdeq_q_count", bus.q_count, 3'd4);
    check("flush_no_fire", bus.bp_fetch_valid, 1'b0);
    sb.delete();
    tick();

    bus.flush = 1'b0; bus.out_ready = 1'b0; bus.bp_pred_taken = 1'b0;
    @(negedge clk);
    check("flush_q_count", bus.q_count, 3'd0);
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_paddr", bus.ic_paddr, 32'h0);
    check("flush_ic_req", bus.ic_req, 1'b1);
    tick();
    tick();

    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
